// File: rtl/led_pkg.sv
// Shared mode encodings, LED constants and counter-sizing helpers for the LED mode controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ALT     = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam logic [1:0] LED_OFF        = 2'b00;
  localparam logic [1:0] LED_ALT_INIT   = 2'b10;
  localparam logic [1:0] LED_BLINK_INIT = 2'b11;
  localparam logic [1:0] LED_ON         = 2'b11;
  localparam logic [7:0] DUTY_MAX       = 8'hFF;

  // Mode sequence advanced by each button press; BREATHE wraps back to OFF.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:     return MODE_ALT;
      MODE_ALT:     return MODE_BLINK;
      MODE_BLINK:   return MODE_BREATHE;
      default:      return MODE_OFF;
    endcase
  endfunction

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-time debounce, one-cycle press pulse.
// Latency: press pulse 2 sync cycles + DEB_CYCLES stable cycles after key_n falls.
// Backpressure: none; the pulse is fire-and-forget.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  import led_pkg::*;

  localparam int unsigned   CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised key disagrees with the accepted level;
  // any agreement (a bounce back) restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Only a released->pressed change of the debounced level is a press.
    press_d = deb_q & ~deb_d;
  end

  // Reset holds everything at the released level so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Two-LED pattern controller: button cycles OFF/ALT/BLINK/BREATHE, patterns driven from a tick and a PWM.
// Latency: mode and LED entry pattern update the cycle after the debounced press pulse.
// Backpressure: none; presses are never queued, each pulse advances one mode.
module led_mode_ctrl #(
  parameter int unsigned TICK_CYCLES = 10_000_000,
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned STEP_CYCLES = 39_062
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic [1:0] led,
  output logic [1:0] mode
);
  import led_pkg::*;

  localparam int unsigned   TW        = cnt_width(TICK_CYCLES);
  localparam int unsigned   SW        = cnt_width(STEP_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic          press;
  logic          tick, step;
  mode_e         mode_q, mode_d;
  logic [1:0]    led_q, led_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic          dir_up_q, dir_up_d;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  assign tick = (tick_cnt_q == TICK_LAST);
  assign step = (step_cnt_q == STEP_LAST);

  // Next-state for mode, pattern counters and LEDs; a press outranks a same-cycle tick.
  always_comb begin
    mode_d     = mode_q;
    led_d      = led_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    step_cnt_d = '0;
    pwm_cnt_d  = '0;
    duty_d     = duty_q;
    dir_up_d   = dir_up_q;

    if (press) begin
      // Every mode change restarts all pattern timing from a clean state.
      mode_d     = next_mode(mode_q);
      tick_cnt_d = '0;
      duty_d     = '0;
      dir_up_d   = 1'b1;
      case (mode_d)
        MODE_ALT:   led_d = LED_ALT_INIT;
        MODE_BLINK: led_d = LED_BLINK_INIT;
        default:    led_d = LED_OFF;  // BREATHE enters with duty 0, so nothing is lit
      endcase
    end else begin
      case (mode_q)
        MODE_ALT: begin
          if (tick) led_d = {led_q[0], led_q[1]};
        end
        MODE_BLINK: begin
          if (tick) led_d = ~led_q;
        end
        MODE_BREATHE: begin
          pwm_cnt_d  = pwm_cnt_q + 8'd1;
          step_cnt_d = step ? '0 : step_cnt_q + SW'(1);
          if (step) begin
            // Turn around at the ends so duty bounces 254,255,254 and 1,0,1.
            if (dir_up_q) begin
              if (duty_q != DUTY_MAX) duty_d = duty_q + 8'd1;
              if (duty_q == DUTY_MAX - 8'd1) dir_up_d = 1'b0;
            end else begin
              if (duty_q != 8'd0) duty_d = duty_q - 8'd1;
              if (duty_q == 8'd1) dir_up_d = 1'b1;
            end
          end
          // Compare against next-state values so the registered LED matches pwm_cnt_q < duty_q.
          led_d = (pwm_cnt_d < duty_d) ? LED_ON : LED_OFF;
        end
        default: led_d = LED_OFF;
      endcase
    end
  end

  // Mode FSM and pattern state registers; reset drops straight to OFF with everything cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_OFF;
      led_q      <= LED_OFF;
      tick_cnt_q <= '0;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      dir_up_q   <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      led_q      <= led_d;
      tick_cnt_q <= tick_cnt_d;
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      dir_up_q   <= dir_up_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with short timing parameters; mode changes scored against a queue.
// Latency: press expected 7 cycles after key_n falls (2 sync + 4 debounce + 1 mode update).
// Backpressure: n/a.
module tb_led_mode_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_n;
  logic [1:0] led;
  logic [1:0] mode;

  led_mode_ctrl #(
    .TICK_CYCLES (8),
    .DEB_CYCLES  (4),
    .STEP_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .led   (led),
    .mode  (mode)
  );

  typedef struct {
    logic [1:0] mode;
    logic [1:0] led;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         press_cnt = 0;
  logic [1:0] prev_mode = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every observed mode change must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_mode = mode;
    end else begin
      if (dut.u_deb.press_q) press_cnt++;
      if (mode !== prev_mode) begin
        if (exp_q.size() == 0) begin
          check("mode_unexpected", mode, prev_mode);
        end else begin
          e = exp_q.pop_front();
          check("mode", mode, e.mode);
          check("entry_led", led, e.led);
          check("entry_cyc", cyc, e.cyc);
        end
        prev_mode = mode;
      end
      if (mode == 2'b11 && dut.duty_q == 8'd0) check("dark_at_duty0", led, 2'b00);
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
    #1;
  endtask

  // Hold the key low for 6 cycles starting at cycle 'start' and queue the resulting mode change.
  task automatic press_key(input int start, input logic [1:0] em, input logic [1:0] el);
    exp_t e;
    do begin
      @(posedge clk);
      #1;
    end while (cyc < start);
    key_n = 1'b0;
    e.mode = em;
    e.led  = el;
    e.cyc  = cyc + 7;
    exp_q.push_back(e);
    repeat (6) @(posedge clk);
    #1;
    key_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s, e_alt, b, r, o, a2, b2, x;
    rst_n = 1'b0;
    key_n = 1'b1;

    // Reset held while the key chatters.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      key_n = ~key_n;
    end
    wait_cyc(cyc + 1);
    check("rst_mode", mode, 2'b00);
    check("rst_led", led, 2'b00);
    key_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(cyc + 20);
    check("post_rst_mode", mode, 2'b00);
    check("post_rst_press", press_cnt, 0);

    // Short glitch rejected.
    s = cyc + 2;
    do begin @(posedge clk); #1; end while (cyc < s);
    key_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    key_n = 1'b1;
    wait_cyc(cyc + 15);
    check("glitch_mode", mode, 2'b00);
    check("glitch_press", press_cnt, 0);

    // OFF -> ALT, then the alternating pattern.
    s = cyc + 2;
    press_key(s, 2'b01, 2'b10);
    e_alt = s + 7;
    wait_cyc(e_alt);
    check("alt_q_empty", exp_q.size(), 0);
    check("alt_mode", mode, 2'b01);
    wait_cyc(e_alt + 7);
    check("alt_led_7", led, 2'b10);
    wait_cyc(e_alt + 8);
    check("alt_led_8", led, 2'b01);
    wait_cyc(e_alt + 15);
    check("alt_led_15", led, 2'b01);
    wait_cyc(e_alt + 16);
    check("alt_led_16", led, 2'b10);
    check("alt_press_once", press_cnt, 1);

    // Press pulse lands on an ALT tick: mode change wins.
    press_key(e_alt + 17, 2'b10, 2'b11);
    b = e_alt + 24;
    wait_cyc(b);
    check("coll_mode", mode, 2'b10);
    check("coll_led", led, 2'b11);
    wait_cyc(b + 7);
    check("blink_led_7", led, 2'b11);
    wait_cyc(b + 8);
    check("blink_led_8", led, 2'b00);
    wait_cyc(b + 16);
    check("blink_led_16", led, 2'b11);

    // BLINK -> BREATHE, duty ramp and turnaround.
    press_key(b + 18, 2'b11, 2'b00);
    r = b + 25;
    wait_cyc(r);
    check("br_duty0", dut.duty_q, 8'd0);
    wait_cyc(r + 300);
    check("br_lit_300", led, 2'b11);
    wait_cyc(r + 509);
    check("br_duty_509", dut.duty_q, 8'd254);
    wait_cyc(r + 510);
    check("br_duty_510", dut.duty_q, 8'd255);
    wait_cyc(r + 512);
    check("br_duty_512", dut.duty_q, 8'd254);

    // BREATHE wraps to OFF.
    press_key(r + 520, 2'b00, 2'b00);
    o = r + 527;
    wait_cyc(o);
    check("wrap_mode", mode, 2'b00);
    wait_cyc(o + 5);
    check("wrap_led", led, 2'b00);

    // Back to BLINK, then reset with the tick counter at 5.
    press_key(o + 8, 2'b01, 2'b10);
    a2 = o + 15;
    press_key(a2 + 10, 2'b10, 2'b11);
    b2 = a2 + 17;
    wait_cyc(b2);
    check("blink2_mode", mode, 2'b10);
    do begin @(posedge clk); #1; end while (cyc < b2 + 5);
    check("mid_tick5", dut.tick_cnt_q, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mode", mode, 2'b00);
    check("mid_rst_led", led, 2'b00);
    check("mid_rst_tick", dut.tick_cnt_q, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    x = cyc;
    wait_cyc(x);
    check("restart_tick0", dut.tick_cnt_q, 0);
    wait_cyc(x + 5);
    check("restart_tick5", dut.tick_cnt_q, 5);
    check("restart_mode", mode, 2'b00);
    check("restart_led", led, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 10_000_000; pattern tick period in clk cycles.
REQ-002 SHALL have parameter DEB_CYCLES, default 1_000_000; key stable time required to accept a level change.
REQ-003 SHALL have parameter STEP_CYCLES, default 39_062; breathe duty-step period in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_n  input  1  raw push-button, asynchronous to clk, low = pressed.
REQ-007 SHALL have port led  output  2  LED drive, 1 = lit.
REQ-008 SHALL have port mode  output  2  current mode: 00 OFF, 01 ALT, 10 BLINK, 11 BREATHE.

Function
REQ-009 SHALL synchronise key_n through two flip-flops before any other use.
REQ-010 SHALL update the debounced key level only after the synchronised key has differed from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-011 SHALL generate a one-cycle press pulse on a 1->0 transition of the debounced level; release generates no pulse.
REQ-012 SHALL implement a mode FSM OFF -> ALT -> BLINK -> BREATHE -> OFF, advancing one state per press pulse, with mode updating in the cycle after the pulse.
REQ-013 SHALL run a tick counter 0..TICK_CYCLES-1 and emit a one-cycle tick at TICK_CYCLES-1, wrapping to 0.
REQ-014 SHALL clear the tick counter on every mode change, so the first tick in a new mode falls TICK_CYCLES cycles after entry.
REQ-015 SHALL, in OFF, drive led = 00.
REQ-016 SHALL, in ALT, load led = 10 on entry and swap the two bits on each tick (10 <-> 01).
REQ-017 SHALL, in BLINK, load led = 11 on entry and toggle between 11 and 00 on each tick.
REQ-018 SHALL, in BREATHE, run an 8-bit free-running PWM counter and an 8-bit duty register, with both LEDs lit while pwm_cnt < duty.
REQ-019 SHALL, in BREATHE, load duty = 0 and direction = up on entry, and step duty by 1 every STEP_CYCLES cycles.
REQ-020 SHALL reverse the duty direction on reaching 255 (going up) or 0 (going down) without overflow or underflow, so the sequence is 254, 255, 254, ... and 1, 0, 1, ...
REQ-021 SHALL, when a press pulse and a tick occur in the same cycle, apply the mode change and ignore the tick.
REQ-022 SHALL produce led and mode from registers, with no combinational path from key_n.

Reset
REQ-023 SHALL, on asserting rst_n, immediately set mode = OFF, led = 00, all counters = 0, duty = 0, direction = up, synchroniser and debounced level = 1 (released).
REQ-024 SHALL abandon any pattern or debounce in progress on reset assertion mid-operation, and SHALL NOT generate a press pulse as a result of reset release.

Structure
REQ-025 SHALL take the mode encodings (MODE_OFF, MODE_ALT, MODE_BLINK, MODE_BREATHE) from shared package led_pkg.
REQ-026 SHALL place synchroniser, debounce and press-pulse logic in sub-module key_debounce, parameterised by DEB_CYCLES.
REQ-027 SHALL size all counters from their parameters, with no fixed widths beyond the 8-bit PWM and duty.

Verification (TICK_CYCLES=8, DEB_CYCLES=4, STEP_CYCLES=2)
REQ-028 SHALL verify reset: hold rst_n=0 with key_n toggling -> led=00, mode=00, no press pulse after release.
REQ-029 SHALL verify debounce: key_n low for 3 cycles then high -> mode stays 00; key_n low for 6 cycles -> mode=01 exactly once, led=10.
REQ-030 SHALL verify ALT and BLINK: in ALT, led 10 -> 01 after 8 cycles -> 10 after 16; one more press -> led=11, then 00 eight cycles after entry.
REQ-031 SHALL verify BREATHE: after entry duty rises to 255 after 510 cycles, then falls to 254; led is never lit when duty=0.
REQ-032 SHALL verify wrap and collision: press in BREATHE -> mode=00, led=00; press aligned with a tick in ALT -> mode=10, no ALT swap.
REQ-033 SHALL verify reset mid-operation: assert rst_n in BLINK with the tick counter at 5 -> mode=00, led=00 in the same cycle, with the tick counter restarting from 0.
